// File: rtl/keypad_entry_ctrl.sv
// Key-sequencing controller behind the 4x4 matrix scanner: assembles a BCD code
// from decoded key events and hands it downstream on a valid/ready handshake.
module keypad_entry_ctrl #(
    parameter int         DIGITS   = 4,
    parameter int         TIME_OUT = 250_000_000,
    parameter logic [3:0] KEY_BS   = 4'hA,
    parameter logic [3:0] KEY_CLR  = 4'hB,
    parameter logic [3:0] KEY_ENT  = 4'hE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            key_num,
    input  logic                  key_vld,
    output logic                  scan_en,
    output logic [4*DIGITS-1:0]   code_bcd,
    output logic [2:0]            code_len,
    output logic                  code_vld,
    input  logic                  code_rdy,
    output logic                  err,
    output logic                  timeout
);
    localparam int             CW      = 4 * DIGITS;
    localparam int             TW      = $clog2(TIME_OUT);
    localparam logic [2:0]     LEN_MAX = 3'(DIGITS);
    localparam logic [TW-1:0]  T_LAST  = TW'(TIME_OUT - 1);

    typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic           is_digit;

    // Function-key parameters take precedence should one ever be mapped onto 0-9.
    assign is_digit = (key_num <= 4'd9) && (key_num != KEY_BS) &&
                      (key_num != KEY_CLR) && (key_num != KEY_ENT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            code_bcd <= '0;
            code_len <= '0;
            code_vld <= 1'b0;
            scan_en  <= 1'b1;
            err      <= 1'b0;
            timeout  <= 1'b0;
            timer    <= '0;
        end else begin
            err     <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (key_vld) begin
                        if (key_num == KEY_ENT) begin
                            err <= 1'b1;
                        end else if (is_digit) begin
                            code_bcd <= CW'(key_num);
                            code_len <= 3'd1;
                            state    <= ENTRY;
                        end
                    end
                end

                ENTRY: begin
                    if (key_vld) begin
                        // Any key, even an ignored one, restarts the idle timer.
                        timer <= '0;
                        if (key_num == KEY_ENT) begin
                            state    <= HOLD;
                            code_vld <= 1'b1;
                            scan_en  <= 1'b0;
                        end else if (key_num == KEY_BS) begin
                            code_bcd <= code_bcd >> 4;
                            code_len <= code_len - 3'd1;
                            if (code_len == 3'd1)
                                state <= IDLE;
                        end else if (key_num == KEY_CLR) begin
                            code_bcd <= '0;
                            code_len <= '0;
                            state    <= IDLE;
                        end else if (is_digit) begin
                            if (code_len == LEN_MAX) begin
                                err <= 1'b1;
                            end else begin
                                code_bcd <= (code_bcd << 4) | CW'(key_num);
                                code_len <= code_len + 3'd1;
                            end
                        end
                    end else if (timer == T_LAST) begin
                        code_bcd <= '0;
                        code_len <= '0;
                        timeout  <= 1'b1;
                        timer    <= '0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                HOLD: begin
                    timer <= '0;
                    if (code_vld && code_rdy) begin
                        code_vld <= 1'b0;
                        scan_en  <= 1'b1;
                        code_bcd <= '0;
                        code_len <= '0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
